// File: rtl/ff_reg_arbiter.sv
// ff_reg_arbiter: round-robin owner of a shared negedge register (req/clr_req/wdata in; gnt/busy/q out)
module ff_reg_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   clr_req,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic           busy,
  output logic [W-1:0]   q
);
  localparam int PW = $clog2(N);
  localparam int HW = $clog2(HOLD_MAX) + 1;
  typedef enum logic {IDLE, OWN} state_t;
  state_t        state;
  logic [PW-1:0] owner, last, pick;
  logic [HW-1:0] hcnt;
  logic          found;
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(last) + k) % N]) begin
        pick = PW'((int'(last) + k) % N);
        found = 1'b1;
      end
    end
  end
  assign busy = |gnt;
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      last  <= PW'(N - 1);
      hcnt  <= '0;
      gnt   <= '0;
      q     <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        owner <= pick;
        last  <= pick;
        gnt   <= N'(1) << pick;
        hcnt  <= '0;
        state <= OWN;
      end
    end else if (!req[owner]) begin
      gnt   <= '0;
      state <= IDLE;
    end else begin
      q    <= clr_req[owner] ? '0 : wdata[int'(owner)*W +: W];
      hcnt <= hcnt + 1'b1;
      if (hcnt == HW'(HOLD_MAX - 1)) begin
        gnt   <= '0;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_ff_reg_arbiter.sv
// tb_ff_reg_arbiter: randomized and directed checks of ff_reg_arbiter against an ownership model
module tb_ff_reg_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int HM = 4;
  logic           clk = 1'b1;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   clr_req = '0;
  logic [N*W-1:0] wdata = '0;
  logic [N-1:0]   gnt;
  logic           busy;
  logic [W-1:0]   q;
  int             checks = 0;
  int             errors = 0;
  int             m_owner, m_last, m_cnt;
  logic [W-1:0]   m_q;
  logic [N-1:0]   eg;

  ff_reg_arbiter #(.N(N), .W(W), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst(rst), .req(req), .clr_req(clr_req), .wdata(wdata),
    .gnt(gnt), .busy(busy), .q(q)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_owner = -1;
    m_last = N - 1;
    m_cnt = 0;
    m_q = '0;
  endtask

  task automatic model_edge();
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++)
        if (m_owner < 0 && req[(m_last + k) % N]) m_owner = (m_last + k) % N;
      if (m_owner >= 0) begin
        m_last = m_owner;
        m_cnt = 0;
      end
    end else if (!req[m_owner]) begin
      m_owner = -1;
    end else begin
      m_q = clr_req[m_owner] ? '0 : wdata[m_owner*W +: W];
      m_cnt++;
      if (m_cnt == HM) m_owner = -1;
    end
    eg = (m_owner < 0) ? '0 : N'(1) << m_owner;
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] c, input logic [N*W-1:0] d);
    @(posedge clk);
    req = r;
    clr_req = c;
    wdata = d;
    @(negedge clk);
    model_edge();
    #1;
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    req = '0;
    clr_req = '0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    eg = '0;
  endtask

  task automatic test_reset();
    model_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      req = N'($urandom);
      clr_req = N'($urandom);
      wdata = $urandom;
      @(negedge clk);
      #1;
      checks++;
      if ({gnt, busy, q} !== {N'(0), 1'b0, W'(0)}) begin
        errors++;
        $display("FAIL reset gnt/busy/q=%b/%b/%h exp 0000/0/00", gnt, busy, q);
      end
    end
    @(posedge clk);
    req = '0;
    clr_req = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    for (int e = 1; e <= 6; e++) begin
      cyc(e <= 5 ? N'(1) : N'(0), '0, 32'h0000_00A5);
      checks++;
      if ({gnt, busy, q} !== {eg, |eg, m_q}) begin
        errors++;
        $display("FAIL single edge %0d gnt/busy/q=%b/%b/%h exp %b/%b/%h", e, gnt, busy, q, eg, |eg, m_q);
      end
    end
    checks++;
    if (q !== 8'hA5) begin
      errors++;
      $display("FAIL single_q q=%h exp a5", q);
    end
  endtask

  task automatic test_clear();
    cyc(4'b0001, '0, 32'h0000_00FF);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL clear_grant gnt=%b exp 0001", gnt);
    end
    cyc(4'b0001, '0, 32'h0000_00FF);
    checks++;
    if (q !== 8'hFF) begin
      errors++;
      $display("FAIL clear_w1 q=%h exp ff", q);
    end
    cyc(4'b0001, 4'b0011, 32'h0000_00FF);
    checks++;
    if (q !== 8'h00 || gnt !== 4'b0001) begin
      errors++;
      $display("FAIL clear_w2 q/gnt=%h/%b exp 00/0001", q, gnt);
    end
    cyc(4'b0000, 4'b0010, 32'hFFFF_FFFF);
    checks++;
    if ({gnt, busy, q} !== {eg, |eg, m_q} || q !== 8'h00) begin
      errors++;
      $display("FAIL clear_release gnt/busy/q=%b/%b/%h exp %b/%b/00", gnt, busy, q, eg, |eg);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] cg;
    rst_pulse();
    for (int e = 0; e <= 20; e++) begin
      cyc(4'b1111, '0, 32'h4433_2211);
      cg = (e % 5 == 4) ? N'(0) : N'(1) << ((e / 5) % N);
      checks++;
      if (gnt !== cg || {gnt, busy, q} !== {eg, |eg, m_q}) begin
        errors++;
        $display("FAIL rr edge %0d gnt/busy/q=%b/%b/%h exp %b/%b/%h", e, gnt, busy, q, cg, |eg, m_q);
      end
    end
    cyc('0, '0, '0);
    cyc('0, '0, '0);
  endtask

  task automatic test_early_release();
    rst_pulse();
    cyc(4'b0100, '0, 32'h003C_0000);
    cyc(4'b0100, '0, 32'h003C_0000);
    cyc(4'b0100, '0, 32'h003C_0000);
    checks++;
    if (gnt !== 4'b0100 || q !== 8'h3C) begin
      errors++;
      $display("FAIL early_hold gnt/q=%b/%h exp 0100/3c", gnt, q);
    end
    cyc(4'b1000, '0, 32'h9900_0000);
    checks++;
    if (gnt !== 4'b0000 || q !== 8'h3C || busy !== 1'b0) begin
      errors++;
      $display("FAIL early_release gnt/busy/q=%b/%b/%h exp 0000/0/3c", gnt, busy, q);
    end
    cyc(4'b1000, '0, 32'h9900_0000);
    checks++;
    if (gnt !== 4'b1000 || q !== 8'h3C) begin
      errors++;
      $display("FAIL early_next gnt/q=%b/%h exp 1000/3c", gnt, q);
    end
    cyc('0, '0, '0);
    cyc('0, '0, '0);
  endtask

  task automatic test_async_reset();
    cyc(4'b0010, '0, 32'h0000_5500);
    cyc(4'b0010, '0, 32'h0000_5500);
    checks++;
    if (gnt !== 4'b0010 || q !== 8'h55) begin
      errors++;
      $display("FAIL arst_setup gnt/q=%b/%h exp 0010/55", gnt, q);
    end
    @(posedge clk);
    req = '0;
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt, busy, q} !== {N'(0), 1'b0, W'(0)}) begin
      errors++;
      $display("FAIL arst_immediate gnt/busy/q=%b/%b/%h exp 0000/0/00", gnt, busy, q);
    end
    #1;
    rst = 1'b0;
    model_reset();
    cyc(4'b0011, '0, 32'h0000_7766);
    checks++;
    if (gnt !== 4'b0001 || q !== 8'h00) begin
      errors++;
      $display("FAIL arst_regrant gnt/q=%b/%h exp 0001/00", gnt, q);
    end
    cyc('0, '0, '0);
    cyc('0, '0, '0);
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    for (int i = 0; i < 400; i++) begin
      r = N'($urandom);
      if ($urandom_range(0, 3) != 0 && m_owner >= 0) r[m_owner] = 1'b1;
      cyc(r, N'($urandom_range(0, 3) == 0 ? $urandom : 0), $urandom);
      checks++;
      if ({gnt, busy, q} !== {eg, |eg, m_q} || $countones(gnt) > 1) begin
        errors++;
        $display("FAIL random cyc %0d gnt/busy/q=%b/%b/%h exp %b/%b/%h", i, gnt, busy, q, eg, |eg, m_q);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_clear();
    test_round_robin();
    test_early_release();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ff_reg_arbiter.md
Name: ff_reg_arbiter

Overview:
- Round-robin arbiter that shares one W-bit register bank of negative-edge, synchronous-clear flip-flops among N requesters.
- A granted requester owns the register for a bounded burst. During the burst, each cycle it either writes data or issues a synchronous clear.
- Sits between requester logic and the shared register. The register's q is exported as the block's output.

Parameters:
- N, 4, number of requesters (≥2).
- W, 8, register data width.
- HOLD_MAX, 4, maximum write edges per ownership before forced release (≥1).

Ports:
- clk  input  1  clock; all state updates on the falling edge.
- rst  input  1  asynchronous reset, active-high.
- req  input  N  per-requester request; bit i = requester i. Must stay high for the whole burst.
- clr_req  input  N  per-requester clear request; only the owner's bit is used.
- wdata  input  N*W  packed write data; requester i uses bits [i*W+W-1 : i*W].
- gnt  output  N  one-hot grant, or all zeros.
- busy  output  1  high while in OWN state.
- q  output  W  shared register value.

Behaviour:
- Reset (rst=1, immediate, independent of clk):
  - gnt=0, busy=0, q=0.
  - State IDLE, hold counter = 0.
  - Round-robin pointer last = N-1, so requester 0 has top priority after reset.
- Timing: all non-reset updates occur on the falling edge of clk. Inputs are sampled at that edge.
- States: IDLE, OWN.
- IDLE, when any req bit is high at the edge:
  - Pick the first i with req[i]=1, searching cyclically from last+1.
  - Set owner=i, last=i, gnt=one-hot(i), hold counter=0, state=OWN.
  - No write on the grant edge.
- IDLE, when no req bit is high: hold all state; q unchanged.
- OWN, when req[owner]=0 at the edge (early release):
  - gnt=0, state=IDLE.
  - No write; q keeps its value.
- OWN, when req[owner]=1 at the edge (write edge):
  - If clr_req[owner]=1: q=0. Clear has priority over data.
  - Otherwise: q = wdata slice of owner.
  - Increment hold counter.
  - If this is the HOLD_MAX-th write edge (forced release): gnt=0, state=IDLE in the same edge.
- Latency:
  - req high to gnt high: 1 falling edge.
  - First q update: second falling edge after req is seen.
- Re-arbitration: exactly one IDLE edge between consecutive owners. That edge is itself the grant edge of the next owner when any req is pending.
- Inputs from non-owners (req, clr_req, wdata) never affect q.
- A requester that keeps req high after a forced release is eligible again only after every other pending requester has been served (round robin).
- Hold counter width: clog2(HOLD_MAX)+1 bits; it never wraps.
- Reset mid-burst: ownership is abandoned and q is cleared. No write is completed on a later edge.
- gnt is always one-hot or zero. busy equals OR of gnt.

Test Plan:
- Reset: rst=1 with random req/wdata and clk toggling → q=0x00, gnt=0000, busy=0 throughout.
- Single write: N=4, W=8, HOLD_MAX=4; req=0001, wdata[7:0]=0xA5 →
  - gnt=0001, busy=1 after falling edge 1.
  - q=0xA5 after falling edge 2.
  - gnt=0000 after falling edge 5.
- Clear priority: owner 0 with wdata[7:0]=0xFF and clr_req=0001 on its 2nd write edge →
  - q=0xFF after write edge 1, q=0x00 after write edge 2.
  - Simultaneous clr_req=0010 from a non-owner has no effect.
- Round robin: req=1111 held, distinct wdata per requester →
  - gnt sequence 0001, 0010, 0100, 1000, 0001.
  - Each grant lasts 4 clock periods, followed by 1 period of gnt=0000.
  - q tracks the owner's wdata.
- Early release: owner 2 drops req after 2 write edges, with q=0x3C →
  - gnt=0000 at the next edge, q stays 0x3C.
  - Next grant follows round robin from 2, e.g. to 3 if pending.
- Async reset mid-burst: rst pulsed high between edges while owner 1 holds with q=0x55 →
  - gnt=0000 and q=0x00 immediately, before any clk edge.
  - After release with req=0011, the first grant goes to requester 0.
